// File: rtl/latch_mem_wide.sv
// Byte-addressed scratch memory with 8/16/32-bit accesses moved in LANE_BYTES-wide beats.
// Optional define LATCH_MEM_RESET_CLEAR_EN: rst also clears every storage byte.
module latch_mem_wide #(
  parameter int RAM_BYTES  = 32,
  parameter int ADDR_BITS  = 5,
  parameter int LANE_BYTES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr_in,
  input  logic [31:0]          data_in,
  input  logic [1:0]           data_write_n,
  input  logic [1:0]           data_read_n,
  output logic [31:0]          data_out,
  output logic                 data_ready
);

  localparam int          IDX_W = (RAM_BYTES > 1) ? $clog2(RAM_BYTES) : 1;
  localparam int unsigned LANE  = LANE_BYTES;
  localparam int unsigned RAM   = RAM_BYTES;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t               state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [2:0]           size_q, size_d;
  logic                 wr_q, wr_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          data_out_q, data_out_d;
  logic                 data_ready_q, data_ready_d;
  logic [7:0]           mem_q [RAM_BYTES];
  logic [7:0]           mem_d [RAM_BYTES];

  logic                 request;
  logic                 beat_go;
  logic                 cur_wr;
  logic [2:0]           cur_size;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [ADDR_BITS-1:0] byte_addr;
  logic [31:0]          cur_data;
  logic [1:0]           cur_beat;
  int unsigned          size_int;
  int unsigned          bpb;
  int unsigned          nbeats;
  int unsigned          bidx;

  function automatic logic [2:0] size_bytes(input logic [1:0] code);
    case (code)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      2'b10:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  assign request = (data_write_n != 2'b11) || (data_read_n != 2'b11);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    size_d       = size_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    data_out_d   = data_out_q;
    data_ready_d = 1'b0;
    mem_d        = mem_q;
    beat_go      = 1'b0;
    cur_wr       = wr_q;
    cur_size     = size_q;
    cur_addr     = addr_q;
    cur_data     = wdata_q;
    cur_beat     = beat_q;
    byte_addr    = '0;
    size_int     = 0;
    bpb          = 0;
    nbeats       = 1;
    bidx         = 0;

    // Beat 0 runs straight from the live inputs so a single-beat access completes in one cycle.
    case (state_q)
      IDLE: begin
        if (request) begin
          cur_wr   = (data_write_n != 2'b11);
          cur_size = size_bytes(cur_wr ? data_write_n : data_read_n);
          cur_addr = addr_in;
          cur_data = data_in;
          cur_beat = '0;
          beat_go  = 1'b1;
          wr_d     = cur_wr;
          size_d   = cur_size;
          addr_d   = addr_in;
          wdata_d  = data_in;
          if (!cur_wr) data_out_d = '0;
        end
      end
      ACCESS: begin
        if (!request) begin
          state_d = IDLE;
          beat_d  = '0;
        end else begin
          beat_go = 1'b1;
        end
      end
      DONE: begin
        if (!request) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (beat_go && !rst) begin
      size_int = 32'(cur_size);
      bpb      = (size_int < LANE) ? size_int : LANE;
      nbeats   = (size_int > LANE) ? size_int / LANE : 1;
      for (int unsigned j = 0; j < LANE; j++) begin
        if (j < bpb) begin
          bidx      = 32'(cur_beat) * LANE + j;
          byte_addr = cur_addr + ADDR_BITS'(bidx);
          if (cur_wr) begin
            if (32'(byte_addr) < RAM) mem_d[IDX_W'(byte_addr)] = cur_data[bidx*8 +: 8];
          end else begin
            data_out_d[bidx*8 +: 8] = (32'(byte_addr) < RAM) ? mem_q[IDX_W'(byte_addr)] : 8'h00;
          end
        end
      end
      if (32'(cur_beat) == nbeats - 1) begin
        state_d      = DONE;
        beat_d       = '0;
        data_ready_d = 1'b1;
      end else begin
        state_d = ACCESS;
        beat_d  = cur_beat + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      size_q       <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      data_out_q   <= '0;
      data_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      size_q       <= size_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
    end
  end

`ifdef LATCH_MEM_RESET_CLEAR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < RAM; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end
`else
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
`endif

  assign data_out   = data_out_q;
  assign data_ready = data_ready_q;

endmodule

// File: tb/tb_latch_mem_wide.sv
// Bench for latch_mem_wide: three configurations share stimulus, each checked against its own byte model.
module tb_latch_mem_wide;

  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  addr_in = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n  = 2'b11;
  logic [31:0] dout [NDUT];
  logic        rdy  [NDUT];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  model   [NDUT][32];
  logic [31:0] exp_q   [NDUT][$];
  logic [31:0] last_rd [NDUT];

  latch_mem_wide #(.RAM_BYTES(32), .ADDR_BITS(5), .LANE_BYTES(1)) u_l1 (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(dout[0]), .data_ready(rdy[0]));

  latch_mem_wide #(.RAM_BYTES(32), .ADDR_BITS(5), .LANE_BYTES(4)) u_l4 (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(dout[1]), .data_ready(rdy[1]));

  latch_mem_wide #(.RAM_BYTES(24), .ADDR_BITS(5), .LANE_BYTES(1)) u_r24 (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(dout[2]), .data_ready(rdy[2]));

  always #5 clk = ~clk;

  function automatic int lane_of(input int d);
    return (d == 1) ? 4 : 1;
  endfunction

  function automatic int ram_of(input int d);
    return (d == 2) ? 24 : 32;
  endfunction

  function automatic int sz_of(input logic [1:0] c);
    case (c)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic clear_models_on_reset();
    for (int d = 0; d < NDUT; d++) begin
      last_rd[d] = '0;
`ifdef LATCH_MEM_RESET_CLEAR_EN
      for (int i = 0; i < 32; i++) model[d][i] = 8'h00;
`endif
    end
  endtask

  // Drives one request for 'hold' edges; reads push expectations, completions pop and compare.
  task automatic access(input logic [1:0] w, input logic [1:0] r, input logic [4:0] a,
                        input logic [31:0] d, input int hold);
    int sz;
    bit is_wr;
    int nb [NDUT];
    int pulses [NDUT];
    int first [NDUT];
    logic [31:0] e;
    is_wr = (w != 2'b11);
    sz = sz_of(is_wr ? w : r);
    for (int dd = 0; dd < NDUT; dd++) begin
      nb[dd] = (sz > lane_of(dd)) ? sz / lane_of(dd) : 1;
      pulses[dd] = 0;
      first[dd] = 0;
      e = '0;
      for (int i = 0; i < sz; i++) begin
        int aa;
        aa = (int'(a) + i) % 32;
        if (aa < ram_of(dd)) begin
          if (is_wr) model[dd][aa] = d[i*8 +: 8];
          else e[i*8 +: 8] = model[dd][aa];
        end
      end
      if (!is_wr) exp_q[dd].push_back(e);
    end
    addr_in = a; data_in = d; data_write_n = w; data_read_n = r;
    for (int cyc = 1; cyc <= hold + 2; cyc++) begin
      @(posedge clk); #1;
      for (int dd = 0; dd < NDUT; dd++) begin
        if (rdy[dd] === 1'b1) begin
          pulses[dd]++;
          if (pulses[dd] == 1) begin
            first[dd] = cyc;
            if (!is_wr) begin
              vectors++;
              if (exp_q[dd].size() == 0) begin
                miscompares++;
                $display("FAIL rd_data dut%0d a=%0d: ready with no expectation queued", dd, a);
              end else begin
                e = exp_q[dd].pop_front();
                if (dout[dd] !== e) begin
                  miscompares++;
                  $display("FAIL rd_data dut%0d a=%0d: got %h expected %h", dd, a, dout[dd], e);
                end
                last_rd[dd] = e;
              end
            end
          end
        end
      end
      if (cyc == hold) begin
        data_write_n = 2'b11; data_read_n = 2'b11;
      end
    end
    for (int dd = 0; dd < NDUT; dd++) begin
      vectors++;
      if (pulses[dd] != 1) begin
        miscompares++;
        $display("FAIL ready_pulses dut%0d a=%0d: got %0d expected 1", dd, a, pulses[dd]);
        if (pulses[dd] == 0 && !is_wr && exp_q[dd].size() > 0) void'(exp_q[dd].pop_front());
      end
      vectors++;
      if (first[dd] != nb[dd]) begin
        miscompares++;
        $display("FAIL latency dut%0d a=%0d: got %0d expected %0d", dd, a, first[dd], nb[dd]);
      end
      if (is_wr) begin
        vectors++;
        if (dout[dd] !== last_rd[dd]) begin
          miscompares++;
          $display("FAIL dout_hold dut%0d: got %h expected %h", dd, dout[dd], last_rd[dd]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int dd = 0; dd < NDUT; dd++) begin
      vectors++;
      if (dout[dd] !== 32'h0 || rdy[dd] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: dout=%h ready=%b expected 0/0", dd, dout[dd], rdy[dd]);
      end
    end
    rst = 1'b0;
    clear_models_on_reset();
  endtask

  task automatic test_fill();
    for (int a = 0; a < 32; a += 4) access(2'b11 ^ 2'b01, 2'b11, 5'(a), $urandom, 5);
  endtask

  task automatic test_spec_vectors();
    access(2'b10, 2'b11, 5'd4, 32'hDEADBEEF, 5);
    access(2'b11, 2'b10, 5'd4, 32'h0, 5);
    access(2'b01, 2'b11, 5'd31, 32'h00001234, 5);
    access(2'b11, 2'b00, 5'd0, 32'h0, 5);
    access(2'b11, 2'b00, 5'd31, 32'h0, 5);
    access(2'b00, 2'b11, 5'd28, 32'h000000AA, 5);
    access(2'b11, 2'b00, 5'd28, 32'h0, 5);
    access(2'b11, 2'b10, 5'd30, 32'h0, 5);
  endtask

  task automatic test_hold();
    access(2'b11, 2'b10, 5'd4, 32'h0, 10);
    access(2'b11, 2'b01, 5'd6, 32'h0, 5);
  endtask

  task automatic test_abort();
    int pulses [NDUT];
    access(2'b10, 2'b11, 5'd8, 32'hFFFFFFFF, 5);
    for (int dd = 0; dd < NDUT; dd++) begin
      pulses[dd] = 0;
      model[dd][8] = 8'h44;
      model[dd][9] = 8'h33;
    end
    model[1][10] = 8'h22;
    model[1][11] = 8'h11;
    addr_in = 5'd8; data_in = 32'h11223344; data_write_n = 2'b10; data_read_n = 2'b11;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(posedge clk); #1;
      for (int dd = 0; dd < NDUT; dd++) if (rdy[dd] === 1'b1) pulses[dd]++;
      if (cyc == 2) begin
        data_write_n = 2'b11; data_read_n = 2'b11;
      end
    end
    for (int dd = 0; dd < NDUT; dd++) begin
      vectors++;
      if (pulses[dd] != ((dd == 1) ? 1 : 0)) begin
        miscompares++;
        $display("FAIL abort_ready dut%0d: got %0d pulses expected %0d", dd, pulses[dd], (dd == 1) ? 1 : 0);
      end
    end
    access(2'b11, 2'b10, 5'd8, 32'h0, 5);
  endtask

  task automatic test_write_wins();
    access(2'b00, 2'b10, 5'd12, 32'h000000A5, 5);
    access(2'b11, 2'b00, 5'd12, 32'h0, 5);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [1:0] code;
      code = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) access(code, 2'b11, 5'($urandom_range(0, 31)), $urandom, 5);
      else access(2'b11, code, 5'($urandom_range(0, 31)), 32'h0, 5);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    addr_in = 5'd0; data_write_n = 2'b11; data_read_n = 2'b10;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; data_read_n = 2'b11;
    clear_models_on_reset();
    for (int dd = 0; dd < NDUT; dd++) begin
      vectors++;
      if (dout[dd] !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_mid_dout dut%0d: got %h expected 0", dd, dout[dd]);
      end
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (rdy[0] === 1'b1 || rdy[2] === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("FAIL reset_mid_ready: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_reset_clear();
    access(2'b00, 2'b11, 5'd3, 32'h00000055, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_models_on_reset();
    access(2'b11, 2'b00, 5'd3, 32'h0, 5);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_spec_vectors();
    test_hold();
    test_abort();
    test_write_wins();
    test_random();
    test_reset_mid();
    test_reset_clear();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/latch_mem_wide.md
LATCH_MEM_WIDE -- requirements
Module: latch_mem_wide

Interface
REQ-001 SHALL have parameter RAM_BYTES, default 32, meaning number of byte locations implemented.
REQ-002 SHALL have parameter ADDR_BITS, default 5, meaning address width; RAM_BYTES <= 2^ADDR_BITS.
REQ-003 SHALL have parameter LANE_BYTES, default 1, meaning bytes transferred per beat; legal values 1, 2, 4.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port addr_in  input  ADDR_BITS  byte address of first byte of the access.
REQ-007 SHALL have port data_in  input  32  write data; bottom 8/16/32 bits valid per size.
REQ-008 SHALL have port data_write_n  input  2  11 none, 00 8-bit, 01 16-bit, 10 32-bit write.
REQ-009 SHALL have port data_read_n  input  2  same encoding, read.
REQ-010 SHALL have port data_out  output  32  registered read data, little-endian, upper bytes zero for narrow reads.
REQ-011 SHALL have port data_ready  output  1  registered one-cycle completion pulse.

Function
REQ-012 SHALL implement states IDLE, ACCESS, DONE.
REQ-013 IDLE: when data_write_n != 11 or data_read_n != 11, latch size, direction, addr_in, data_in; perform beat 0 in that cycle; go ACCESS (or DONE if beat 0 is the final beat).
REQ-014 Beat count N = max(1, size_bytes / LANE_BYTES); beat k covers bytes addr + k*LANE_BYTES .. + LANE_BYTES-1.
REQ-015 Byte address arithmetic SHALL wrap modulo 2^ADDR_BITS.
REQ-016 Bytes whose wrapped address >= RAM_BYTES: writes dropped, reads return 0x00.
REQ-017 Narrow access within a wide lane (size_bytes < LANE_BYTES) SHALL touch only size_bytes bytes.
REQ-018 Writes SHALL take effect at the edge ending their beat; a read in the following cycle SHALL see new data.
REQ-019 Read beat k SHALL register its bytes into data_out lane k at the edge ending the beat; untouched upper bytes cleared to 0 at access start.
REQ-020 ACCESS: one beat per cycle while the request stays asserted; after final beat go DONE.
REQ-021 data_ready SHALL be high exactly one cycle, the cycle after the final beat edge, with data_out complete.
REQ-022 Latency: 32-bit access with LANE_BYTES=1 -> data_ready 4 cycles after request first seen; LANE_BYTES=4 -> 1 cycle.
REQ-023 DONE: remain until both data_write_n and data_read_n are 11, then IDLE; no new access accepted in DONE.
REQ-024 Request withdrawn (both 11) in ACCESS: abort to IDLE, completed write beats retained, no data_ready.
REQ-025 Read and write requested together: write SHALL win, read ignored.
REQ-026 Size or address changes after acceptance SHALL be ignored until IDLE.
REQ-027 data_out SHALL hold its value when no read beat occurs.

Reset
REQ-028 rst high at a rising edge: state IDLE, beat counter 0, data_out 0, data_ready 0.
REQ-029 rst SHALL override any in-progress access; no data_ready for the aborted access; storage per REQ-030/031.

Configuration
REQ-030 Macro LATCH_MEM_RESET_CLEAR_EN defined: rst SHALL clear every storage byte to 0x00 at the same edge.
REQ-031 Macro undefined: storage SHALL be unaffected by rst and implemented without reset logic.

Verification
REQ-032 LANE_BYTES=1: write 32-bit 0xDEADBEEF at addr 4, read 32-bit addr 4 -> data_out 0xDEADBEEF, data_ready 4 cycles after read request.
REQ-033 LANE_BYTES=4: write 16-bit 0x1234 at addr 31 (RAM_BYTES=32), read 8-bit addr 0 -> 0x00000012; read addr 31 -> 0x00000034.
REQ-034 RAM_BYTES=24, ADDR_BITS=5: write 8-bit 0xAA at addr 28, read addr 28 -> 0x00000000.
REQ-035 Read 32-bit, hold request 10 cycles -> exactly one data_ready pulse; next read accepted only after request released.
REQ-036 Write 32-bit, withdraw after 2 beats (LANE_BYTES=1) -> bytes 0-1 written, bytes 2-3 unchanged, no data_ready.
REQ-037 Write 0x55 at addr 3, pulse rst, read addr 3 -> 0x00 with LATCH_MEM_RESET_CLEAR_EN, 0x55 without.
